led_frame_serializer: RTL and testbench

Consumes the 432-bit `stringLight` frame assembled by the SPI receiver and drives a WS2812-style single-wire LED chain: 18 LEDs × 24 bits, MSB first, pulse-width encoded. It sits directly downstream of the SPI stage and runs in the `clk` domain. The upstream `start` strobe is already synchronized into `clk`. The block owns the only pin to the LED string.

---
 rtl/led_frame_serializer.sv | 122 ++++++++++++
 tb/tb_led_frame_serializer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_serializer.sv
// WS2812-style serializer: captures a frame on start, sends it MSB first as
// pulse-width encoded bits, then holds the line low for the latch period.
module led_frame_serializer #(
  parameter int unsigned NUM_LEDS     = 18,
  parameter int unsigned BITS_PER_LED = 24,
  parameter int unsigned T0H          = 20,
  parameter int unsigned T1H          = 40,
  parameter int unsigned TBIT         = 60,
  parameter int unsigned TRST         = 3000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_LEDS*BITS_PER_LED-1:0] frame,
  input  logic                             start,
  output logic                             led_dout,
  output logic                             busy,
  output logic                             frame_done
);

  localparam int unsigned NBITS = NUM_LEDS * BITS_PER_LED;
  localparam int unsigned BW    = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int unsigned PW    = (TBIT > 1) ? $clog2(TBIT) : 1;
  localparam int unsigned LW    = (TRST > 1) ? $clog2(TRST) : 1;

  localparam logic [BW-1:0] BitLast = BW'(NBITS - 1);
  localparam logic [PW-1:0] PhLast  = PW'(TBIT - 1);
  localparam logic [PW-1:0] T0hCnt  = PW'(T0H);
  localparam logic [PW-1:0] T1hCnt  = PW'(T1H);
  localparam logic [LW-1:0] LatLast = LW'(TRST - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSend  = 2'd1;
  localparam logic [1:0] StLatch = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [NBITS-1:0] shadow_q, shadow_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [LW-1:0]    latch_q, latch_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    latch_d  = latch_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StSend;
          shadow_d = frame;
          bit_d    = '0;
          phase_d  = '0;
          latch_d  = '0;
        end
      end
      StSend: begin
        if (phase_q == PhLast) begin
          phase_d  = '0;
          // Shadow shifts left so the bit in flight is always its MSB.
          shadow_d = shadow_q << 1;
          if (bit_q == BitLast) begin
            state_d = StLatch;
            bit_d   = '0;
            latch_d = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StLatch: begin
        if (latch_q == LatLast) begin
          state_d = StIdle;
          latch_d = '0;
        end else begin
          latch_d = latch_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the current state, one cycle behind it.
  always_comb begin
    dout_d = (state_q == StSend) &&
             (phase_q < (shadow_q[NBITS-1] ? T1hCnt : T0hCnt));
    busy_d = (state_q != StIdle);
    done_d = (state_q == StLatch) && (latch_q == LatLast);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      bit_q    <= '0;
      phase_q  <= '0;
      latch_q  <= '0;
      dout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      latch_q  <= latch_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign led_dout   = dout_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_led_frame_serializer.sv
// Bench for led_frame_serializer: a waveform model derived from the frame timing
// rules is compared against the DUT outputs every cycle, plus per-frame totals.
module tb_led_frame_serializer;

  localparam int unsigned NL  = 2;
  localparam int unsigned BPL = 24;
  localparam int unsigned T0  = 2;
  localparam int unsigned T1  = 4;
  localparam int unsigned TB  = 6;
  localparam int unsigned TR  = 20;
  localparam int          TOTAL = NL * BPL;
  localparam longint      SENDC = longint'(TOTAL) * longint'(TB);
  localparam longint      LEN   = SENDC + longint'(TR);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [TOTAL-1:0] frame = '0;
  logic             led_dout, busy, frame_done;

  led_frame_serializer #(
    .NUM_LEDS    (NL),
    .BITS_PER_LED(BPL),
    .T0H         (T0),
    .T1H         (T1),
    .TBIT        (TB),
    .TRST        (TR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame     (frame),
    .start     (start),
    .led_dout  (led_dout),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_pass = 0;
  longint edge_idx = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_idx);
  endtask

  // Model: a frame accepted at edge N owns outputs for edges N+1 .. N+LEN.
  bit               m_active = 1'b0;
  longint           m_n0 = 0;
  logic [TOTAL-1:0] m_fr = '0;

  initial forever begin
    @(posedge clk);
    edge_idx++;
    if (reset) m_active = 1'b0;
    else if (start && (!m_active || edge_idx >= m_n0 + LEN + 1)) begin
      m_active = 1'b1;
      m_n0     = edge_idx;
      m_fr     = frame;
    end
  end

  function automatic logic [2:0] exp_out(input longint e);
    longint d, k, p;
    logic   b, dout;
    if (reset || !m_active) return 3'b000;
    d = e - m_n0;
    if (d < 1 || d > LEN) return 3'b000;
    dout = 1'b0;
    if (d <= SENDC) begin
      k    = (d - 1) / TB;
      p    = (d - 1) % TB;
      b    = m_fr[int'(TOTAL - 1 - k)];
      dout = (p < (b ? longint'(T1) : longint'(T0)));
    end
    return {dout, 1'b1, (d == LEN)};
  endfunction

  int     hi_cnt = 0;
  int     done_cnt = 0;
  longint done_q[$];

  initial forever begin
    @(negedge clk);
    check_eq("out", longint'({led_dout, busy, frame_done}), longint'(exp_out(edge_idx)));
    hi_cnt += int'(led_dout);
    if (frame_done) begin
      done_cnt++;
      done_q.push_back(edge_idx);
    end
  end

  function automatic logic [TOTAL-1:0] rand_frame();
    logic [TOTAL-1:0] r;
    for (int i = 0; i < TOTAL; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    longint n = 0;
    tick(2);
    while (busy && n < 2 * (LEN + 1)) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_idle", longint'(busy), 0);
    tick(2);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int h0, d0;
  logic [TOTAL-1:0] f;

  initial begin
    @(negedge clk);
    check_eq("reset_state", longint'({led_dout, busy, frame_done}), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    tick(3);

    // All-zero frame: short pulses, done exactly LEN edges after acceptance
    h0 = hi_cnt; d0 = done_cnt;
    frame = '0;
    pulse_start();
    wait_idle();
    check_eq("zero_hi", longint'(hi_cnt - h0), longint'(TOTAL) * T0);
    check_eq("zero_done", longint'(done_cnt - d0), 1);
    check_eq("zero_done_t", done_q[$] - m_n0, LEN);

    // All-ones frame: long pulses
    h0 = hi_cnt;
    frame = '1;
    pulse_start();
    wait_idle();
    check_eq("ones_hi", longint'(hi_cnt - h0), longint'(TOTAL) * T1);

    // Only LED 0 red byte set; frame changes right after capture
    h0 = hi_cnt;
    f = '0;
    f[TOTAL-1 -: 8] = 8'hFF;
    frame = f;
    pulse_start();
    frame = '1;
    wait_idle();
    check_eq("shadow_hi", longint'(hi_cnt - h0), 8 * T1 + longint'(TOTAL - 8) * T0);

    // Starts during SEND and LATCH are ignored
    d0 = done_cnt;
    frame = rand_frame();
    pulse_start();
    tick(100);
    pulse_start();
    tick(int'(LEN) - 110);
    pulse_start();
    wait_idle();
    check_eq("ignored_done", longint'(done_cnt - d0), 1);

    // Start held high: three back-to-back frames
    d0 = done_cnt;
    start = 1'b1;
    for (int i = 0; i < 2 * (int'(LEN) + 1) + 1; i++) begin
      @(negedge clk);
      frame = rand_frame();
    end
    start = 1'b0;
    wait_idle();
    check_eq("held_done", longint'(done_cnt - d0), 3);
    if (done_q.size() >= 3) begin
      check_eq("held_gap1", done_q[$] - done_q[$-1], LEN + 1);
      check_eq("held_gap2", done_q[$-1] - done_q[$-2], LEN + 1);
    end else begin
      check_eq("held_done_q", longint'(done_q.size()), 3);
    end

    // Async reset in the high phase of bit 20
    f = rand_frame();
    f[TOTAL-1-20] = 1'b1;
    frame = f;
    pulse_start();
    d0 = done_cnt;
    repeat (20 * TB + 2) @(posedge clk);
    #1 check_eq("pre_rst_high", longint'(led_dout), 1);
    #1 reset = 1'b1;
    #1 check_eq("async_rst", longint'({led_dout, busy, frame_done}), 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    h0 = hi_cnt;
    tick(30);
    check_eq("post_rst_busy", longint'(busy), 0);
    check_eq("post_rst_hi", longint'(hi_cnt - h0), 0);
    check_eq("post_rst_done", longint'(done_cnt - d0), 0);
    frame = rand_frame();
    pulse_start();
    wait_idle();
    check_eq("replay_done", longint'(done_cnt - d0), 1);

    // Random start strobes and frame churn
    for (int i = 0; i < 4 * (int'(LEN) + 1); i++) begin
      @(negedge clk);
      frame = rand_frame();
      start = ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
